// File: rtl/game_if.sv
// Controller <-> game datapath bus: commands and enables in, status and display out.
interface game_if;
  logic       r1, r2;
  logic       e1, e2, e3, e4;
  logic       sel;
  logic [3:0] sw;
  logic [3:0] key;
  logic       end_fpga, end_user, end_time, win, match;
  logic [3:0] leds;
  logic [4:0] disp;

  modport master (
    output r1, r2, e1, e2, e3, e4, sel, sw, key,
    input  end_fpga, end_user, end_time, win, match, leds, disp
  );

  modport slave (
    input  r1, r2, e1, e2, e3, e4, sel, sw, key,
    output end_fpga, end_user, end_time, win, match, leds, disp
  );
endinterface

// File: rtl/game_datapath.sv
// Memory-game datapath: sequence playback on LEDs, user key checking,
// round timer and score display. Sequencing is owned by an external controller.
module game_datapath #(
  parameter int DISP_CYC = 25000000,
  parameter int TIME_CYC = 250000000
) (
  input  logic   clock,
  input  logic   reset,
  game_if.slave  bus
);

  localparam int DW = $clog2(DISP_CYC + 1);
  localparam int TW = $clog2(TIME_CYC + 1);

  logic [1:0]    seq_id, level;
  logic [3:0]    round, idx, key_q;
  logic          phase;
  logic [DW-1:0] dcnt;
  logic [4:0]    press_cnt;
  logic          err;
  logic [TW-1:0] tcnt;
  logic          win_flag, end_fpga, end_user, end_time;

  // elem(s,i) = (3*i + s + i/4) mod 4; everything is mod 4 so 2-bit math suffices
  function automatic logic [1:0] elem(input logic [1:0] s, input logic [3:0] i);
    return 2'(i[1:0] + i[1:0] + i[1:0] + s + i[3:2]);
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] e);
    return 4'b0001 << e;
  endfunction

  logic [3:0] kedge, exp_key;
  logic [4:0] rnd_p1;
  logic       press, correct, win;

  assign kedge   = bus.key & ~key_q;
  assign exp_key = onehot(elem(seq_id, press_cnt[3:0]));
  // exp_key is one-hot, so equality also rejects multi-key presses
  assign correct = (kedge == exp_key);
  assign press   = bus.e2 & ~end_user & (|kedge);
  assign rnd_p1  = {1'b0, round} + 5'd1;
  // target-1 = 4*(level+1)-1 = {level,2'b11}
  assign win     = (round == {level, 2'b11});

  assign bus.win      = win;
  assign bus.match    = ~err & (press_cnt == rnd_p1);
  assign bus.end_fpga = end_fpga;
  assign bus.end_user = end_user;
  assign bus.end_time = end_time;
  assign bus.disp     = bus.sel ? ({1'b0, round} + {4'b0, win_flag}) : rnd_p1;

  // LED source select: playback (on phase), live keys, win indication
  always_comb begin
    bus.leds = 4'b0000;
    if (bus.e3 && !phase) bus.leds = onehot(elem(seq_id, idx));
    else if (bus.e2)      bus.leds = bus.key;
    else if (bus.sel)     bus.leds = {4{win_flag}};
  end

  // All datapath state: reset > r1 > r2 > enable-driven updates
  always_ff @(posedge clock) begin
    if (reset) begin
      seq_id <= '0; level <= '0; round <= '0; idx <= '0; key_q <= '0;
      phase <= 1'b0; dcnt <= '0; press_cnt <= '0; err <= 1'b0; tcnt <= '0;
      win_flag <= 1'b0; end_fpga <= 1'b0; end_user <= 1'b0; end_time <= 1'b0;
    end else if (bus.r1) begin
      round <= '0; idx <= '0; key_q <= '0;
      phase <= 1'b0; dcnt <= '0; press_cnt <= '0; err <= 1'b0; tcnt <= '0;
      win_flag <= 1'b0; end_fpga <= 1'b0; end_user <= 1'b0; end_time <= 1'b0;
    end else begin
      key_q <= bus.key;
      if (bus.e1) begin
        seq_id <= bus.sw[1:0];
        level  <= bus.sw[3:2];
      end
      if (bus.r2) begin
        idx <= '0; phase <= 1'b0; dcnt <= '0; press_cnt <= '0; err <= 1'b0;
        tcnt <= '0; end_fpga <= 1'b0; end_user <= 1'b0; end_time <= 1'b0;
        win_flag <= win;
        // Round stops at the winning round (so disp with sel shows points = target)
        // and never wraps past 15.
        if (!win && round != 4'd15) round <= round + 4'd1;
      end else begin
        // Playback: on/off halves of DISP_CYC each; freeze in the off phase once done
        if (!bus.e3) begin
          idx <= '0; phase <= 1'b0; dcnt <= '0; end_fpga <= 1'b0;
        end else if (!end_fpga) begin
          if (dcnt == DW'(DISP_CYC - 1)) begin
            dcnt <= '0;
            if (phase && idx == round) begin
              end_fpga <= 1'b1;
            end else begin
              phase <= ~phase;
              if (phase) idx <= idx + 4'd1;
            end
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end

        // Key presses: count every press, latch any error, stop after last/erroneous one
        if (press) begin
          press_cnt <= press_cnt + 5'd1;
          if (!correct) err <= 1'b1;
          if (!correct || (press_cnt + 5'd1) == rnd_p1) end_user <= 1'b1;
        end

        // Round timer: end_time rises together with tcnt reaching TIME_CYC-1
        if (!bus.e2) begin
          tcnt     <= '0;
          end_time <= 1'b0;
        end else begin
          if (tcnt != TW'(TIME_CYC - 1)) tcnt <= tcnt + TW'(1);
          if (tcnt == TW'(TIME_CYC - 2)) end_time <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_game_datapath.sv
// Directed bench for game_datapath with DISP_CYC=2, TIME_CYC=20.
module tb_game_datapath;

  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  game_if bus();

  game_datapath #(.DISP_CYC(2), .TIME_CYC(20)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] seq0 [4];
  logic [3:0] play_leds [4];

  initial begin
    seq0[0] = 4'b0001; seq0[1] = 4'b1000; seq0[2] = 4'b0100; seq0[3] = 4'b0010;
    play_leds[0] = 4'b0001; play_leds[1] = 4'b0001;
    play_leds[2] = 4'b0000; play_leds[3] = 4'b0000;

    reset = 1'b1;
    bus.r1 = 0; bus.r2 = 0; bus.e1 = 0; bus.e2 = 0; bus.e3 = 0; bus.e4 = 0;
    bus.sel = 0; bus.sw = 4'b0000; bus.key = 4'b0000;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_end_fpga", bus.end_fpga, 0);
    chk("rst_end_user", bus.end_user, 0);
    chk("rst_end_time", bus.end_time, 0);
    chk("rst_match", bus.match, 0);
    chk("rst_win", bus.win, 0);
    chk("rst_leds", bus.leds, 4'b0000);
    chk("rst_disp", bus.disp, 5'd1);

    // Setup seq 0, level 1 (target 8)
    bus.e1 = 1; bus.sw = 4'b0100; tick();
    bus.e1 = 0; bus.sw = 4'b0000; settle();
    chk("setup_win", bus.win, 0);

    // Playback round 0
    bus.e3 = 1; settle();
    for (int c = 1; c <= 5; c++) begin
      if (c <= 4) chk($sformatf("play_leds_c%0d", c), bus.leds, play_leds[c-1]);
      chk($sformatf("play_end_c%0d", c), bus.end_fpga, (c == 5) ? 1 : 0);
      if (c < 5) tick();
    end
    bus.e3 = 0; tick();
    chk("play_end_clr", bus.end_fpga, 0);

    // Round 0: one correct press
    bus.e2 = 1; bus.key = 4'b0001; settle();
    chk("e2_leds_key", bus.leds, 4'b0001);
    tick();
    chk("r0_end_user", bus.end_user, 1);
    chk("r0_match", bus.match, 1);
    bus.key = 0; bus.e2 = 0; bus.e4 = 1; tick();
    chk("r0_e4_match", bus.match, 1);
    chk("r0_e4_win", bus.win, 0);
    chk("r0_e4_end_user", bus.end_user, 1);
    bus.e4 = 0;

    // Round 1: correct then wrong press
    bus.r2 = 1; tick(); bus.r2 = 0; settle();
    chk("r1_disp", bus.disp, 5'd2);
    chk("r1_clr_end_user", bus.end_user, 0);
    chk("r1_clr_match", bus.match, 0);
    bus.e2 = 1; bus.key = 4'b0001; tick();
    chk("r1_p1_end_user", bus.end_user, 0);
    chk("r1_p1_match", bus.match, 0);
    bus.key = 0; tick();
    bus.key = 4'b0100; tick();
    chk("r1_p2_end_user", bus.end_user, 1);
    chk("r1_p2_match", bus.match, 0);
    bus.key = 0; bus.e2 = 0; tick();

    // Timeout: e2 held with no presses
    bus.r2 = 1; tick(); bus.r2 = 0;
    bus.e2 = 1;
    for (int j = 1; j <= 19; j++) begin
      tick();
      chk($sformatf("tmo_c%0d", j + 1), bus.end_time, (j == 19) ? 1 : 0);
    end
    bus.e2 = 0; tick();
    chk("tmo_clr", bus.end_time, 0);

    // Level 0: four correct rounds to win
    bus.r1 = 1; tick(); bus.r1 = 0;
    bus.e1 = 1; bus.sw = 4'b0000; tick(); bus.e1 = 0;
    for (int r = 0; r < 4; r++) begin
      bus.e2 = 1;
      for (int i = 0; i <= r; i++) begin
        bus.key = seq0[i]; tick();
        bus.key = 0; tick();
      end
      chk($sformatf("win_r%0d_end_user", r), bus.end_user, 1);
      chk($sformatf("win_r%0d_match", r), bus.match, 1);
      chk($sformatf("win_r%0d_win", r), bus.win, (r == 3) ? 1 : 0);
      bus.e2 = 0;
      bus.r2 = 1; tick(); bus.r2 = 0;
    end
    bus.sel = 1; settle();
    chk("win_disp_sel", bus.disp, 5'd4);
    chk("win_leds_sel", bus.leds, 4'b1111);
    bus.sel = 0; settle();

    // Seq 2, simultaneous keys -> error; r1 keeps seq_id
    bus.r1 = 1; tick(); bus.r1 = 0;
    bus.e1 = 1; bus.sw = 4'b0010; tick(); bus.e1 = 0; bus.sw = 0;
    bus.e2 = 1; bus.key = 4'b0011; tick();
    chk("dual_end_user", bus.end_user, 1);
    chk("dual_match", bus.match, 0);
    bus.key = 0; bus.e2 = 0; tick();
    bus.r1 = 1; tick(); bus.r1 = 0; settle();
    chk("r1_match", bus.match, 0);
    chk("r1_end_user", bus.end_user, 0);
    chk("r1_disp", bus.disp, 5'd1);
    bus.sel = 1; settle();
    chk("r1_winflag_clr", bus.leds, 4'b0000);
    bus.sel = 0;
    bus.e3 = 1; settle();
    chk("r1_seq_kept", bus.leds, 4'b0100);
    bus.e3 = 0;

    // Reset overrides r2 and clears seq_id
    bus.r2 = 1; reset = 1; tick(); reset = 0; bus.r2 = 0; settle();
    chk("rst_ovr_disp", bus.disp, 5'd1);
    bus.e3 = 1; settle();
    chk("rst_seq_clr", bus.leds, 4'b0001);
    bus.e3 = 0; tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
